// File: rtl/pkg_alu.sv
// ALU operation codes understood by every if_alu server.
package pkg_alu;
   typedef enum logic [2:0] {
      ALU_NOP = 3'd0,
      ALU_ADD = 3'd1,
      ALU_SUB = 3'd2,
      ALU_AND = 3'd3,
      ALU_OR  = 3'd4,
      ALU_XOR = 3'd5
   } alu_op_t;
endpackage

// File: rtl/pkg_alu_mul.sv
// State encoding of the sequential shift-add multiplier.
package pkg_alu_mul;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;
endpackage

// File: rtl/pkg_reg.sv
// Register-file wide constants shared across datapath blocks.
package pkg_reg;
   localparam int unsigned REG_WIDTH = 64;
endpackage

// File: rtl/if_alu.sv
// Combinational ALU request/result bundle between a client and a server.
interface if_alu #(
   parameter int unsigned W = pkg_reg::REG_WIDTH
) ();
   pkg_alu::alu_op_t op;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic [W-1:0]     s;
   logic             cf;
   logic             of;
   logic             zf;
   logic             sf;

   modport client (output op, output a, output b,
                   input s, input cf, input of, input zf, input sf);
   modport server (input op, input a, input b,
                   output s, output cf, output of, output zf, output sf);
endinterface

// File: rtl/dev_alu.sv
// Purely combinational ALU server; cf is carry on ADD and borrow on SUB.
module dev_alu
   import pkg_alu::*;
#(
   parameter int unsigned W = pkg_reg::REG_WIDTH
) (
   if_alu.server alu
);
   logic [W:0] sum;

   always_comb begin
      sum    = '0;
      alu.s  = '0;
      alu.cf = 1'b0;
      alu.of = 1'b0;
      unique case (alu.op)
         ALU_ADD: begin
            sum    = {1'b0, alu.a} + {1'b0, alu.b};
            alu.s  = sum[W-1:0];
            alu.cf = sum[W];
            alu.of = (alu.a[W-1] == alu.b[W-1]) && (sum[W-1] != alu.a[W-1]);
         end
         ALU_SUB: begin
            sum    = {1'b0, alu.a} - {1'b0, alu.b};
            alu.s  = sum[W-1:0];
            alu.cf = sum[W];
            alu.of = (alu.a[W-1] != alu.b[W-1]) && (sum[W-1] != alu.a[W-1]);
         end
         ALU_AND: alu.s = alu.a & alu.b;
         ALU_OR:  alu.s = alu.a | alu.b;
         ALU_XOR: alu.s = alu.a ^ alu.b;
         default: alu.s = '0;
      endcase
      alu.zf = (alu.s == '0);
      alu.sf = alu.s[W-1];
   end
endmodule

// File: rtl/alu_mul_seq.sv
// Unsigned WIDTH x WIDTH multiplier: one shift-add step per clock, using an
// external ALU for the partial-sum addition.
module alu_mul_seq
   import pkg_alu::*;
   import pkg_alu_mul::*;
#(
   parameter int unsigned WIDTH = pkg_reg::REG_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_hi,
   output logic [WIDTH-1:0] rsp_lo,
   output logic             rsp_ovf,
   if_alu.client            alu
);
   localparam int unsigned   CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   mul_state_t       state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_ovf_q, rsp_ovf_d;

   always_comb begin
      alu.op = ALU_NOP;
      alu.a  = '0;
      alu.b  = '0;
      if (state_q == RUN && lo_q[0]) begin
         alu.op = ALU_ADD;
         alu.a  = mcand_q;
         alu.b  = hi_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      mcand_d     = mcand_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_ovf_d   = rsp_ovf_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               mcand_d   = req_a;
               lo_d      = req_b;
               hi_d      = '0;
               cnt_d     = '0;
               rsp_ovf_d = 1'b0;
               state_d   = RUN;
            end
         end
         RUN: begin
            // {hi,lo} shifts right one bit per step; the ALU carry enters at the top
            if (lo_q[0]) begin
               {hi_d, lo_d} = {alu.cf, alu.s, lo_q[WIDTH-1:1]};
            end else begin
               {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d     = DONE;
               rsp_valid_d = 1'b1;
               rsp_ovf_d   = (hi_d != '0);
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mcand_q     <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_ovf_q   <= rsp_ovf_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_ovf   = rsp_ovf_q;
   assign rsp_hi    = hi_q;
   assign rsp_lo    = lo_q;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq paired with a dev_alu server.
module tb_alu_mul_seq;
   import pkg_alu::*;

   localparam int unsigned W = 64;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_hi;
   logic [W-1:0] rsp_lo;
   logic         rsp_ovf;

   int unsigned  checks   = 0;
   int unsigned  failures = 0;
   logic [128:0] sb[$];

   if_alu #(.W(W)) alu_if ();

   dev_alu #(.W(W)) u_alu (.alu(alu_if));

   alu_mul_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_hi    (rsp_hi),
      .rsp_lo    (rsp_lo),
      .rsp_ovf   (rsp_ovf),
      .alu       (alu_if)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic mul_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int unsigned hold, input bit nop_chk);
      logic [127:0] prod;
      logic [128:0] exp_e;
      int unsigned  wait_n;
      int unsigned  edges;
      int unsigned  bad_op;
      prod = {64'd0, a} * {64'd0, b};
      @(negedge clk);
      wait_n = 0;
      while (!req_ready && wait_n < 200) begin
         @(negedge clk);
         wait_n++;
      end
      if (!req_ready) begin
         check_eq("ready_timeout", 128'(req_ready), 128'(1));
         return;
      end
      req_a     = a;
      req_b     = b;
      req_valid = 1'b1;
      sb.push_back({|prod[127:64], prod});
      @(negedge clk);
      req_valid = (hold != 0);
      req_a     = ~a;
      req_b     = ~b;
      check_eq("busy_ready", 128'(req_ready), 128'(0));
      edges  = 0;
      bad_op = 0;
      while (!rsp_valid && edges < W + 16) begin
         if (alu_if.op != ALU_NOP) bad_op++;
         @(negedge clk);
         edges++;
      end
      check_eq("latency", 128'(edges), 128'(W));
      exp_e = sb.pop_front();
      if (!rsp_valid) begin
         check_eq("rsp_valid", 128'(rsp_valid), 128'(1));
         return;
      end
      if (nop_chk) check_eq("run_nop_cycles", 128'(bad_op), 128'(0));
      check_eq("product", {rsp_hi, rsp_lo}, exp_e[127:0]);
      check_eq("ovf", 128'(rsp_ovf), 128'(exp_e[128]));
      for (int i = 0; i < int'(hold); i++) begin
         @(negedge clk);
         check_eq("hold_product", {rsp_hi, rsp_lo}, exp_e[127:0]);
         check_eq("hold_ctrl", 128'({rsp_valid, req_ready, rsp_ovf}), 128'({2'b10, exp_e[128]}));
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("handover", 128'({rsp_valid, req_ready}), 128'(2'b01));
      req_valid = 1'b0;
   endtask

   initial begin
      int unsigned vcount;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      #3;
      check_eq("rst_ready", 128'(req_ready), 128'(1));
      check_eq("rst_valid_ovf", 128'({rsp_valid, rsp_ovf}), 128'(0));
      check_eq("rst_product", {rsp_hi, rsp_lo}, 128'(0));
      check_eq("rst_alu_op", 128'(alu_if.op), 128'(ALU_NOP));
      check_eq("rst_alu_ab", {alu_if.a, alu_if.b}, 128'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;

      mul_op(64'd3, 64'd5, 0, 1'b0);
      mul_op('1, '1, 0, 1'b0);
      check_eq("max_hi_const", 128'(rsp_hi), 128'(64'hFFFF_FFFF_FFFF_FFFE));
      mul_op(64'hDEAD, 64'd0, 0, 1'b1);
      mul_op(64'h1234_5678, 64'h9ABC_DEF0, 10, 1'b0);
      mul_op(64'd1, '1, 0, 1'b0);
      mul_op(64'h8000_0000_0000_0000, 64'd2, 0, 1'b0);

      // abort an operation mid-RUN with an asynchronous reset
      @(negedge clk);
      req_a     = 64'hFFFF_0000_FFFF_0000;
      req_b     = 64'h0F0F_0F0F_0F0F_0F0F;
      req_valid = 1'b1;
      sb.push_back('0);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (19) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      sb.delete();
      check_eq("abort_ready", 128'(req_ready), 128'(1));
      check_eq("abort_valid", 128'(rsp_valid), 128'(0));
      check_eq("abort_product", {rsp_hi, rsp_lo}, 128'(0));
      check_eq("abort_alu_op", 128'(alu_if.op), 128'(ALU_NOP));
      @(negedge clk);
      rst = 1'b0;
      vcount = 0;
      repeat (80) begin
         @(negedge clk);
         if (rsp_valid) vcount++;
      end
      check_eq("abort_no_rsp", 128'(vcount), 128'(0));
      mul_op(64'd7, 64'd9, 0, 1'b0);
      check_eq("after_abort_63", {rsp_hi, rsp_lo}, 128'(63));

      for (int n = 0; n < 1000; n++) begin
         mul_op({$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0);
      end

      check_eq("sb_empty", 128'(sb.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default pkg_reg::REG_WIDTH, giving operand width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a multiply request is offered.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 The block SHALL have port req_a, input, WIDTH bits: unsigned multiplicand.
REQ-007 The block SHALL have port req_b, input, WIDTH bits: unsigned multiplier.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: a result is held.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port rsp_hi, output, WIDTH bits: upper half of the product.
REQ-011 The block SHALL have port rsp_lo, output, WIDTH bits: lower half of the product.
REQ-012 The block SHALL have port rsp_ovf, output, 1 bit: product exceeds WIDTH bits (rsp_hi != 0).
REQ-013 The block SHALL have port alu, if_alu.client: it drives op/a/b and reads s/cf/of/zf/sf of an ALU server.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 In IDLE: req_ready=1; on req_valid, latch mcand=req_a, lo=req_b, hi=0, cnt=0; go to RUN.
REQ-016 In RUN and DONE: req_ready=0; requests are ignored and are not queued.
REQ-017 In RUN, when lo[0]=1: drive alu.op=ALU_ADD, alu.b=hi, alu.a=mcand; next {hi,lo} = {alu.cf, alu.s, lo[WIDTH-1:1]}.
REQ-018 In RUN, when lo[0]=0: drive alu.op=ALU_NOP; next {hi,lo} = {1'b0, hi, lo[WIDTH-1:1]}; alu.s is not used.
REQ-019 Each RUN cycle SHALL increment cnt; after the WIDTH-th iteration the FSM goes to DONE.
REQ-020 Latency: rsp_valid SHALL rise exactly WIDTH clock edges after the accepting edge.
REQ-021 In DONE: rsp_valid=1 with stable rsp_hi/rsp_lo/rsp_ovf; on rsp_ready the FSM goes to IDLE.
REQ-022 A new request SHALL NOT be accepted in the same cycle as the DONE->IDLE handover.
REQ-023 Outside RUN the block SHALL drive alu.op=ALU_NOP, alu.a=0, alu.b=0.
REQ-024 cnt SHALL be wide enough to hold WIDTH without wrap; arithmetic is unsigned only.
REQ-025 alu.of, alu.zf and alu.sf SHALL be ignored; carry comes only from alu.cf of an ALU_ADD cycle.
REQ-026 rsp_hi/rsp_lo SHALL reflect the working registers, and rsp_ovf SHALL be a registered compare.

Reset
REQ-027 While rst=1: state=IDLE, hi=lo=mcand=0, cnt=0, rsp_valid=0, rsp_ovf=0, alu.op=ALU_NOP, independent of clk.
REQ-028 Reset during RUN or DONE SHALL discard the operation; no rsp_valid pulse follows.

Structure
REQ-029 The FSM state typedef SHALL live in a shared package pkg_alu_mul; op codes SHALL come from pkg_alu.
REQ-030 No sub-module SHALL be used; the ALU is external, and the bench connects a dev_alu server through if_alu.

Verification
REQ-031 WIDTH=64, a=3, b=5 -> rsp_hi=0, rsp_lo=15, rsp_ovf=0, and rsp_valid rises 64 edges after acceptance.
REQ-032 a=b=2^64-1 -> rsp_hi=0xFFFF_FFFF_FFFF_FFFE, rsp_lo=1, rsp_ovf=1.
REQ-033 a=0xDEAD, b=0 -> product 0, with alu.op=ALU_NOP on every RUN cycle.
REQ-034 Hold rsp_ready=0 for 10 cycles in DONE, with req_valid=1 throughout -> outputs stable, req_ready=0, no second accept until the cycle after the rsp_ready handshake.
REQ-035 Assert rst asynchronously at cycle 20 of RUN -> state=IDLE immediately, rsp_valid stays 0, and the next request 7*9 returns 63.
REQ-036 Random unsigned a and b (1000 pairs) -> {rsp_hi,rsp_lo} equals the 128-bit reference product.
